// File: rtl/rand_byte_packer_pkg.sv
// Shared constants and types for the TRNG byte path.
// Imported by the packer and its output FIFO.
package rand_byte_packer_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_REP_LIMIT  = 32;
    localparam int RUN_W          = 8;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [RUN_W-1:0]  run_t;

    // Run length after accepting bit b, given the previous bit and run.
    // A run of zero means no bit has been seen since reset.
    function automatic run_t next_run(
        input run_t run,
        input logic prev,
        input logic b
    );
        if (run != '0 && b == prev) begin
            return run + run_t'(1);
        end
        return run_t'(1);
    endfunction

endpackage

// File: rtl/rand_byte_fifo.sv
// Byte FIFO for the packer: write/read on one clock, level output.
// A write to a full FIFO only succeeds when a read frees a slot that edge.
module rand_byte_fifo
    import rand_byte_packer_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr,
    input  byte_t                  i_wr_data,
    input  logic                   i_rd,
    output byte_t                  o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_drop,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    byte_t         mem [DEPTH];
    logic          do_wr;
    logic          do_rd;

    assign o_full    = (cnt == (AW+1)'(DEPTH));
    assign o_empty   = (cnt == '0);
    assign do_rd     = i_rd && !o_empty;
    assign do_wr     = i_wr && (!o_full || do_rd);
    assign o_drop    = i_wr && !do_wr;
    assign o_rd_data = mem[rd_ptr];
    assign o_level   = cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= i_wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rand_byte_packer.sv
// Packs debiased random bits MSB-first into bytes and buffers them.
// A repetition-count health test permanently stops byte production.
module rand_byte_packer
    import rand_byte_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_random,
    input  logic                        i_valid,
    input  logic                        i_ready,
    output logic [BYTE_W-1:0]           o_data,
    output logic                        o_valid,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_overflow,
    output logic                        o_health_fail
);

    logic [BYTE_W-2:0] shift_q;
    logic [2:0]        bit_cnt_q;
    run_t              run_q;
    logic              last_q;
    logic              hf_q;
    logic              ovf_q;

    logic  accept;
    run_t  run_d;
    logic  trip;
    logic  push;
    byte_t byte_d;
    logic  empty;
    logic  full;
    logic  drop;

    assign accept = i_valid && !hf_q;
    assign run_d  = next_run(run_q, last_q, i_random);
    assign trip   = accept && (run_d == run_t'(REP_LIMIT));
    assign push   = accept && !trip && (bit_cnt_q == 3'd7);
    assign byte_d = {shift_q, i_random};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            run_q     <= '0;
            last_q    <= 1'b0;
            hf_q      <= 1'b0;
        end else if (trip) begin
            // The tripping bit and the partial byte are discarded.
            hf_q      <= 1'b1;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            run_q     <= run_d;
        end else if (accept) begin
            shift_q   <= byte_d[BYTE_W-2:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            run_q     <= run_d;
            last_q    <= i_random;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    rand_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr      (push),
        .i_wr_data (byte_d),
        .i_rd      (i_ready),
        .o_rd_data (o_data),
        .o_full    (full),
        .o_empty   (empty),
        .o_drop    (drop),
        .o_level   (o_level)
    );

    assign o_valid       = !empty;
    assign o_overflow    = ovf_q;
    assign o_health_fail = hf_q;

    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_rand_byte_packer.sv
// Randomized and directed bench for rand_byte_packer.
// Outputs are compared each cycle against a queue-based byte model.
module tb_rand_byte_packer;
    import rand_byte_packer_pkg::*;

    localparam int D  = DEF_FIFO_DEPTH;
    localparam int RL = DEF_REP_LIMIT;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_random;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic [2:0] o_level;
    logic       o_overflow;
    logic       o_health_fail;

    always #5 i_clk = ~i_clk;

    rand_byte_packer dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_random      (i_random),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_level       (o_level),
        .o_overflow    (o_overflow),
        .o_health_fail (o_health_fail)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: bytes are whole list entries, the partial byte is a bit count.
    int         mq[$];
    int         pbits;
    logic [7:0] pacc;
    int         run;
    bit         lastb;
    bit         movf;
    bit         mhf;

    function automatic void model_reset();
        mq.delete();
        pbits = 0;
        pacc  = 8'h00;
        run   = 0;
        lastb = 1'b0;
        movf  = 1'b0;
        mhf   = 1'b0;
    endfunction

    function automatic void model_edge(input bit v, input bit b, input bit r);
        if (r && mq.size() > 0) void'(mq.pop_front());
        if (v && !mhf) begin
            run   = (run > 0 && b == lastb) ? run + 1 : 1;
            lastb = b;
            if (run == RL) begin
                mhf   = 1'b1;
                pbits = 0;
            end else begin
                pacc = {pacc[6:0], b};
                pbits++;
                if (pbits == 8) begin
                    pbits = 0;
                    if (mq.size() < D) mq.push_back(int'(pacc));
                    else movf = 1'b1;
                end
            end
        end
    endfunction

    task automatic check_outs();
        check("valid", 32'(o_valid), 32'(mq.size() > 0));
        check("level", 32'(o_level), 32'(mq.size()));
        check("ovf", 32'(o_overflow), 32'(movf));
        check("hfail", 32'(o_health_fail), 32'(mhf));
        if (mq.size() > 0) check("data", 32'(o_data), 32'(mq[0]));
    endtask

    task automatic tick(input bit v, input bit b, input bit r);
        i_valid  = v;
        i_random = b;
        i_ready  = r;
        model_edge(v, b, r);
        @(posedge i_clk);
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        i_valid  = 1'b0;
        i_random = 1'b0;
        i_ready  = 1'b0;
        i_rst    = 1'b1;
        #2;
        model_reset();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_data", 32'(o_data), 32'h00);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        check("rst_hf", 32'(o_health_fail), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] v, input int gap, input bit r);
        for (int i = 7; i >= 0; i--) begin
            int g;
            g = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
            for (int k = 0; k < g; k++) tick(1'b0, 1'b0, r);
            tick(1'b1, v[i], r);
        end
    endtask

    task automatic drain_expect(input logic [7:0] exp, input string tag);
        check(tag, 32'(o_data), 32'(exp));
        tick(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_random = 1'b0;
        i_ready  = 1'b0;
        do_reset();

        // Back-to-back 0xB2, no byte before the 8th bit.
        for (int i = 7; i >= 1; i--) tick(1'b1, 1'(8'hB2 >> i), 1'b0);
        check("b2_early", 32'(o_valid), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        check("b2_data", 32'(o_data), 32'hB2);
        check("b2_level", 32'(o_level), 32'd1);

        do_reset();
        push_byte(8'hB2, 3, 1'b0);
        check("b2gap_data", 32'(o_data), 32'hB2);
        check("b2gap_level", 32'(o_level), 32'd1);

        // Overflow with five bytes into a depth-4 FIFO.
        do_reset();
        for (int n = 1; n <= 5; n++) push_byte(8'(n), 0, 1'b0);
        check("ovf_level", 32'(o_level), 32'd4);
        check("ovf_flag", 32'(o_overflow), 32'd1);
        for (int n = 1; n <= 4; n++) drain_expect(8'(n), "ovf_drain");
        check("ovf_empty", 32'(o_valid), 32'd0);

        // Simultaneous read and write while full.
        do_reset();
        for (int n = 1; n <= 4; n++) push_byte(8'(n), 0, 1'b0);
        for (int i = 7; i >= 1; i--) tick(1'b1, 1'(8'h77 >> i), 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        check("rw_level", 32'(o_level), 32'd4);
        check("rw_ovf", 32'(o_overflow), 32'd0);
        for (int n = 2; n <= 4; n++) drain_expect(8'(n), "rw_drain");
        drain_expect(8'h77, "rw_last");
        check("rw_empty", 32'(o_valid), 32'd0);

        // Repetition test trips on the RL-th identical bit.
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (i == RL - 1) check("hf_before", 32'(o_health_fail), 32'd0);
            if (i == RL) check("hf_trip", 32'(o_health_fail), 32'd1);
        end
        check("hf_level", 32'(o_level), 32'd3);
        for (int n = 0; n < 3; n++) drain_expect(8'hFF, "hf_drain");
        check("hf_empty", 32'(o_valid), 32'd0);

        // Reset mid-byte discards the partial byte.
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
        do_reset();
        push_byte(8'hA5, 0, 1'b0);
        check("mid_data", 32'(o_data), 32'hA5);
        check("mid_ovf", 32'(o_overflow), 32'd0);
        check("mid_hf", 32'(o_health_fail), 32'd0);

        // Random traffic, slow then fast consumer.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 15) == 0);
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 9) < 7);
        end
        // Low-entropy source to exercise the health test under random flow.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            tick($urandom_range(0, 1) != 0, $urandom_range(0, 31) != 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rand_byte_packer.md
RAND_BYTE_PACKER -- requirements
Module: rand_byte_packer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, number of byte entries buffered (power of two, >=2).
REQ-002 The block SHALL have parameter REP_LIMIT, default 32, run length of identical accepted bits that declares a health failure (2..255).
REQ-003 The block SHALL have port i_clk  input  1  single clock, rising edge; all state is in this domain.
REQ-004 The block SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_random  input  1  debiased random bit, sampled only when i_valid=1.
REQ-006 The block SHALL have port i_valid  input  1  qualifies i_random for one clock.
REQ-007 The block SHALL have port i_ready  input  1  consumer accepts o_data this cycle.
REQ-008 The block SHALL have port o_data  output  8  byte at FIFO head.
REQ-009 The block SHALL have port o_valid  output  1  FIFO non-empty; o_data is meaningful.
REQ-010 The block SHALL have port o_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 The block SHALL have port o_overflow  output  1  sticky: a completed byte was dropped because the FIFO was full.
REQ-012 The block SHALL have port o_health_fail  output  1  sticky: repetition-count test tripped.

Function
REQ-013 Each edge with i_valid=1 and o_health_fail=0 SHALL shift i_random into the assembly register at the LSB and increment a 3-bit bit counter; the first accepted bit of a byte ends at bit 7.
REQ-014 On the edge accepting the 8th bit (counter=7), the byte {shift[6:0], i_random} SHALL be written to the FIFO on that same edge, the counter SHALL wrap to 0, and o_valid SHALL be high in the following cycle (1-cycle latency).
REQ-015 A read transfer SHALL occur on each edge where o_valid=1 and i_ready=1; the head advances and o_data shows the next entry in the following cycle.
REQ-016 o_data and o_valid SHALL be stable while o_valid=1 and i_ready=0.
REQ-017 Write with FIFO full and no simultaneous read: the byte SHALL be dropped, o_overflow SHALL set, and the counter SHALL still wrap to 0.
REQ-018 Write and read on the same edge with FIFO full: both SHALL complete, o_level unchanged, no overflow.
REQ-019 Write and read on the same edge with FIFO empty: the read SHALL NOT occur (o_valid=0); the write completes, o_level becomes 1.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; o_level SHALL range 0..FIFO_DEPTH and never wrap.
REQ-021 A run counter SHALL count consecutive accepted bits equal to the previous accepted bit (first bit after reset counts as run length 1); a differing bit resets the run to 1.
REQ-022 When the run length reaches REP_LIMIT, o_health_fail SHALL set on that edge; that bit and all later bits SHALL be ignored, the partial byte SHALL be discarded, and no further FIFO writes occur.
REQ-023 After o_health_fail sets, bytes already in the FIFO SHALL remain readable normally.
REQ-024 o_overflow and o_health_fail SHALL clear only by reset.
REQ-025 i_valid=0 SHALL leave the assembly register, bit counter and run counter unchanged.

Reset
REQ-026 While i_rst=1 all state SHALL be cleared asynchronously: o_valid=0, o_level=0, o_data=0x00, o_overflow=0, o_health_fail=0, bit counter=0, run counter=0.
REQ-027 Reset asserted mid-byte or mid-run SHALL discard the partial byte and run history; the first accepted bit after release starts a new byte and a run of 1.
REQ-028 The first edge after i_rst deasserts SHALL be able to accept a bit.

Structure
REQ-029 Default FIFO_DEPTH, default REP_LIMIT and the byte width (8) SHALL live in the shared package/include used by the TRNG blocks.
REQ-030 The FIFO SHALL be a sub-module rand_byte_fifo (synchronous write/read, full/empty, level); assembly and health test SHALL stay in the top.

Verification
REQ-031 Reset, then 8 valid bits 1,0,1,1,0,0,1,0 back-to-back, i_ready=0 -> o_valid=1 one cycle after the 8th bit, o_data=0xB2, o_level=1.
REQ-032 Same 8 bits with i_valid gaps of 0-3 idle cycles between them -> identical result 0xB2; no byte before the 8th bit.
REQ-033 i_ready=0, push 5 bytes 0x01..0x05 (DEPTH=4) -> o_level=4, o_overflow=1; draining yields 0x01,0x02,0x03,0x04 then o_valid=0.
REQ-034 FIFO full, i_ready=1 held while the 8th bit of byte 0x77 arrives -> read and write on the same edge, o_level stays 4, o_overflow=0, 0x77 emerges last.
REQ-035 REP_LIMIT=32, feed 40 bits of 1 -> o_health_fail=1 on the 32nd bit; exactly 3 bytes 0xFF written (bits 1-24), bits 25-40 produce nothing; the 3 bytes remain readable.
REQ-036 Assert i_rst after 5 bits of a byte, release, feed 8 bits 0xA5 -> o_data=0xA5, all sticky flags 0.
